// File: rtl/session_mux_pkg.sv
// Shared constants and helpers for the multi-channel session-table mux.
// Width defaults match the cuckoo_cam session interface.
package session_mux_pkg;

    localparam int unsigned LUP_REQ_W = 72;
    localparam int unsigned UPD_REQ_W = 88;
    localparam int unsigned RSP_W     = 88;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/session_class_arb.sv
// One request class: round-robin arbiter into a single output register,
// channel-ID order FIFO, and in-order reply demux back to the channels.
module session_class_arb
    import session_mux_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned REQ_W     = 72,
    parameter int unsigned RSP_W     = 88,
    parameter int unsigned ORD_DEPTH = 16,
    localparam int unsigned CNT_W    = clog2(ORD_DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH*REQ_W-1:0]  i_req_tdata,
    input  logic [NUM_CH-1:0]        i_req_tvalid,
    output logic [NUM_CH-1:0]        o_req_tready,
    output logic [REQ_W-1:0]         o_cam_req_tdata,
    output logic                     o_cam_req_tvalid,
    input  logic                     i_cam_req_tready,
    input  logic [RSP_W-1:0]         i_cam_rsp_tdata,
    input  logic                     i_cam_rsp_tvalid,
    output logic                     o_cam_rsp_tready,
    output logic [NUM_CH*RSP_W-1:0]  o_rsp_tdata,
    output logic [NUM_CH-1:0]        o_rsp_tvalid,
    input  logic [NUM_CH-1:0]        i_rsp_tready,
    output logic [CNT_W-1:0]         o_outstanding,
    output logic                     o_proto_err
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W = (ORD_DEPTH > 1) ? clog2(ORD_DEPTH) : 1;

    logic [CH_W-1:0]  r_rr_ptr;
    logic             r_req_valid;
    logic [REQ_W-1:0] r_req_data;
    logic [CH_W-1:0]  r_ord_mem [ORD_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_proto_err;

    logic             w_found;
    logic [CH_W-1:0]  w_grant_ch;
    logic [REQ_W-1:0] w_grant_data;
    logic             w_can_load;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_grant;
    logic [CH_W-1:0]  w_head_ch;
    logic             w_pop;

    // Cyclic search for the first valid channel starting at the RR pointer.
    always_comb begin
        int unsigned idx;
        w_found      = 1'b0;
        w_grant_ch   = '0;
        w_grant_data = '0;
        idx          = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(r_rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!w_found && i_req_tvalid[CH_W'(idx)]) begin
                w_found      = 1'b1;
                w_grant_ch   = CH_W'(idx);
                w_grant_data = i_req_tdata[idx*REQ_W +: REQ_W];
            end
        end
    end

    assign w_can_load   = !r_req_valid || i_cam_req_tready;
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CNT_W'(ORD_DEPTH));
    // Reset gates the grant so no channel sees tready while held in reset.
    assign w_grant      = i_rst_n && w_found && w_can_load && !w_fifo_full;

    always_comb begin
        o_req_tready = '0;
        if (w_grant) begin
            o_req_tready[w_grant_ch] = 1'b1;
        end
    end

    assign w_head_ch        = r_ord_mem[r_rd_ptr];
    assign o_cam_rsp_tready = !w_fifo_empty && i_rsp_tready[w_head_ch];
    assign w_pop            = i_cam_rsp_tvalid && o_cam_rsp_tready;
    assign o_rsp_tdata      = {NUM_CH{i_cam_rsp_tdata}};

    always_comb begin
        o_rsp_tvalid = '0;
        if (i_cam_rsp_tvalid && !w_fifo_empty) begin
            o_rsp_tvalid[w_head_ch] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr    <= '0;
            r_req_valid <= 1'b0;
            r_req_data  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_req_valid <= 1'b1;
                r_req_data  <= w_grant_data;
                r_rr_ptr    <= (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : w_grant_ch + CH_W'(1);
                r_wr_ptr    <= (r_wr_ptr == PTR_W'(ORD_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end else if (i_cam_req_tready) begin
                r_req_valid <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(ORD_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (i_cam_rsp_tvalid && w_fifo_empty) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_grant) begin
            r_ord_mem[r_wr_ptr] <= w_grant_ch;
        end
    end

    assign o_cam_req_tdata  = r_req_data;
    assign o_cam_req_tvalid = r_req_valid;
    assign o_outstanding    = r_count;
    assign o_proto_err      = r_proto_err;

endmodule

// File: rtl/session_lookup_mux.sv
// Shares one cuckoo_cam session table between NUM_CH TOE channels; lookup
// and update classes are arbitrated and tracked independently.
module session_lookup_mux
    import session_mux_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned LUP_REQ_W = session_mux_pkg::LUP_REQ_W,
    parameter int unsigned UPD_REQ_W = session_mux_pkg::UPD_REQ_W,
    parameter int unsigned LUP_RSP_W = session_mux_pkg::RSP_W,
    parameter int unsigned UPD_RSP_W = session_mux_pkg::RSP_W,
    parameter int unsigned ORD_DEPTH = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,

    input  logic [NUM_CH*LUP_REQ_W-1:0]   s_axis_lup_req_tdata,
    input  logic [NUM_CH-1:0]             s_axis_lup_req_tvalid,
    output logic [NUM_CH-1:0]             s_axis_lup_req_tready,
    input  logic [NUM_CH*UPD_REQ_W-1:0]   s_axis_upd_req_tdata,
    input  logic [NUM_CH-1:0]             s_axis_upd_req_tvalid,
    output logic [NUM_CH-1:0]             s_axis_upd_req_tready,

    output logic [LUP_REQ_W-1:0]          m_axis_cam_lup_req_tdata,
    output logic                          m_axis_cam_lup_req_tvalid,
    input  logic                          m_axis_cam_lup_req_tready,
    output logic [UPD_REQ_W-1:0]          m_axis_cam_upd_req_tdata,
    output logic                          m_axis_cam_upd_req_tvalid,
    input  logic                          m_axis_cam_upd_req_tready,

    input  logic [LUP_RSP_W-1:0]          s_axis_cam_lup_rsp_tdata,
    input  logic                          s_axis_cam_lup_rsp_tvalid,
    output logic                          s_axis_cam_lup_rsp_tready,
    input  logic [UPD_RSP_W-1:0]          s_axis_cam_upd_rsp_tdata,
    input  logic                          s_axis_cam_upd_rsp_tvalid,
    output logic                          s_axis_cam_upd_rsp_tready,

    output logic [NUM_CH*LUP_RSP_W-1:0]   m_axis_lup_rsp_tdata,
    output logic [NUM_CH-1:0]             m_axis_lup_rsp_tvalid,
    input  logic [NUM_CH-1:0]             m_axis_lup_rsp_tready,
    output logic [NUM_CH*UPD_RSP_W-1:0]   m_axis_upd_rsp_tdata,
    output logic [NUM_CH-1:0]             m_axis_upd_rsp_tvalid,
    input  logic [NUM_CH-1:0]             m_axis_upd_rsp_tready,

    output logic [clog2(ORD_DEPTH+1)-1:0] lup_outstanding,
    output logic [clog2(ORD_DEPTH+1)-1:0] upd_outstanding,
    output logic                          proto_err
);

    logic w_lup_err;
    logic w_upd_err;

    session_class_arb #(
        .NUM_CH    (NUM_CH),
        .REQ_W     (LUP_REQ_W),
        .RSP_W     (LUP_RSP_W),
        .ORD_DEPTH (ORD_DEPTH)
    ) u_lup (
        .i_clk            (ap_clk),
        .i_rst_n          (ap_rst_n),
        .i_req_tdata      (s_axis_lup_req_tdata),
        .i_req_tvalid     (s_axis_lup_req_tvalid),
        .o_req_tready     (s_axis_lup_req_tready),
        .o_cam_req_tdata  (m_axis_cam_lup_req_tdata),
        .o_cam_req_tvalid (m_axis_cam_lup_req_tvalid),
        .i_cam_req_tready (m_axis_cam_lup_req_tready),
        .i_cam_rsp_tdata  (s_axis_cam_lup_rsp_tdata),
        .i_cam_rsp_tvalid (s_axis_cam_lup_rsp_tvalid),
        .o_cam_rsp_tready (s_axis_cam_lup_rsp_tready),
        .o_rsp_tdata      (m_axis_lup_rsp_tdata),
        .o_rsp_tvalid     (m_axis_lup_rsp_tvalid),
        .i_rsp_tready     (m_axis_lup_rsp_tready),
        .o_outstanding    (lup_outstanding),
        .o_proto_err      (w_lup_err)
    );

    session_class_arb #(
        .NUM_CH    (NUM_CH),
        .REQ_W     (UPD_REQ_W),
        .RSP_W     (UPD_RSP_W),
        .ORD_DEPTH (ORD_DEPTH)
    ) u_upd (
        .i_clk            (ap_clk),
        .i_rst_n          (ap_rst_n),
        .i_req_tdata      (s_axis_upd_req_tdata),
        .i_req_tvalid     (s_axis_upd_req_tvalid),
        .o_req_tready     (s_axis_upd_req_tready),
        .o_cam_req_tdata  (m_axis_cam_upd_req_tdata),
        .o_cam_req_tvalid (m_axis_cam_upd_req_tvalid),
        .i_cam_req_tready (m_axis_cam_upd_req_tready),
        .i_cam_rsp_tdata  (s_axis_cam_upd_rsp_tdata),
        .i_cam_rsp_tvalid (s_axis_cam_upd_rsp_tvalid),
        .o_cam_rsp_tready (s_axis_cam_upd_rsp_tready),
        .o_rsp_tdata      (m_axis_upd_rsp_tdata),
        .o_rsp_tvalid     (m_axis_upd_rsp_tvalid),
        .i_rsp_tready     (m_axis_upd_rsp_tready),
        .o_outstanding    (upd_outstanding),
        .o_proto_err      (w_upd_err)
    );

    assign proto_err = w_lup_err | w_upd_err;

endmodule

// File: tb/tb_session_lookup_mux.sv
// Directed bench for session_lookup_mux with a queue-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_session_lookup_mux;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [143:0]  s_lup_tdata;
    logic [1:0]    s_lup_tvalid, s_lup_tready;
    logic [175:0]  s_upd_tdata;
    logic [1:0]    s_upd_tvalid, s_upd_tready;
    logic [71:0]   cam_lup_req_tdata;
    logic          cam_lup_req_tvalid, cam_lup_req_tready;
    logic [87:0]   cam_upd_req_tdata;
    logic          cam_upd_req_tvalid, cam_upd_req_tready;
    logic [87:0]   cam_lup_rsp_tdata, cam_upd_rsp_tdata;
    logic          cam_lup_rsp_tvalid, cam_lup_rsp_tready;
    logic          cam_upd_rsp_tvalid, cam_upd_rsp_tready;
    logic [175:0]  m_lup_rsp_tdata, m_upd_rsp_tdata;
    logic [1:0]    m_lup_rsp_tvalid, m_lup_rsp_tready;
    logic [1:0]    m_upd_rsp_tvalid, m_upd_rsp_tready;
    logic [4:0]    lup_outstanding, upd_outstanding;
    logic          proto_err;

    logic [87:0]   lup_d [2];
    logic [87:0]   upd_d [2];

    assign s_lup_tdata = {lup_d[1][71:0], lup_d[0][71:0]};
    assign s_upd_tdata = {upd_d[1], upd_d[0]};

    always #5 ap_clk = ~ap_clk;

    session_lookup_mux #(
        .NUM_CH    (2),
        .ORD_DEPTH (16)
    ) dut (
        .ap_clk                     (ap_clk),
        .ap_rst_n                   (ap_rst_n),
        .s_axis_lup_req_tdata       (s_lup_tdata),
        .s_axis_lup_req_tvalid      (s_lup_tvalid),
        .s_axis_lup_req_tready      (s_lup_tready),
        .s_axis_upd_req_tdata       (s_upd_tdata),
        .s_axis_upd_req_tvalid      (s_upd_tvalid),
        .s_axis_upd_req_tready      (s_upd_tready),
        .m_axis_cam_lup_req_tdata   (cam_lup_req_tdata),
        .m_axis_cam_lup_req_tvalid  (cam_lup_req_tvalid),
        .m_axis_cam_lup_req_tready  (cam_lup_req_tready),
        .m_axis_cam_upd_req_tdata   (cam_upd_req_tdata),
        .m_axis_cam_upd_req_tvalid  (cam_upd_req_tvalid),
        .m_axis_cam_upd_req_tready  (cam_upd_req_tready),
        .s_axis_cam_lup_rsp_tdata   (cam_lup_rsp_tdata),
        .s_axis_cam_lup_rsp_tvalid  (cam_lup_rsp_tvalid),
        .s_axis_cam_lup_rsp_tready  (cam_lup_rsp_tready),
        .s_axis_cam_upd_rsp_tdata   (cam_upd_rsp_tdata),
        .s_axis_cam_upd_rsp_tvalid  (cam_upd_rsp_tvalid),
        .s_axis_cam_upd_rsp_tready  (cam_upd_rsp_tready),
        .m_axis_lup_rsp_tdata       (m_lup_rsp_tdata),
        .m_axis_lup_rsp_tvalid      (m_lup_rsp_tvalid),
        .m_axis_lup_rsp_tready      (m_lup_rsp_tready),
        .m_axis_upd_rsp_tdata       (m_upd_rsp_tdata),
        .m_axis_upd_rsp_tvalid      (m_upd_rsp_tvalid),
        .m_axis_upd_rsp_tready      (m_upd_rsp_tready),
        .lup_outstanding            (lup_outstanding),
        .upd_outstanding            (upd_outstanding),
        .proto_err                  (proto_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: per class, the pending CAM slot, RR pointer and a
    // ring of channel IDs awaiting replies.
    int          m_rr  [2];
    bit          m_rv  [2];
    logic [87:0] m_rd  [2];
    int          m_ord [2][16];
    int          m_hd  [2];
    int          m_cnt [2];
    bit          m_perr;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_rr[c] = 0; m_rv[c] = 0; m_rd[c] = '0; m_hd[c] = 0; m_cnt[c] = 0;
        end
        m_perr = 0;
    endtask

    initial begin
        string       cn;
        logic [1:0]  vld, rsprdy, a_srdy, a_rspv, e_srdy, e_rspv;
        logic [87:0] din [2];
        logic [87:0] rspd, a_md, a_rd0, a_rd1;
        logic        crdy, rspv, a_mv, a_crdy, e_crdy;
        logic [4:0]  a_out;
        bit          perr_set;
        int          gnt, ch, tail;
        model_reset();
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                model_reset();
                chk("rst.lup_s_tready", 256'(s_lup_tready), 256'(0));
                chk("rst.upd_s_tready", 256'(s_upd_tready), 256'(0));
                chk("rst.cam_lup_tvalid", 256'(cam_lup_req_tvalid), 256'(0));
                chk("rst.cam_upd_tvalid", 256'(cam_upd_req_tvalid), 256'(0));
                chk("rst.lup_rsp_tvalid", 256'(m_lup_rsp_tvalid), 256'(0));
                chk("rst.upd_rsp_tvalid", 256'(m_upd_rsp_tvalid), 256'(0));
                chk("rst.lup_outstanding", 256'(lup_outstanding), 256'(0));
                chk("rst.upd_outstanding", 256'(upd_outstanding), 256'(0));
                chk("rst.proto_err", 256'(proto_err), 256'(0));
            end else begin
                perr_set = 0;
                chk("model.proto_err", 256'(proto_err), 256'(m_perr));
                for (int c = 0; c < 2; c++) begin
                    if (c == 0) begin
                        cn = "lup"; vld = s_lup_tvalid; rsprdy = m_lup_rsp_tready;
                        din[0] = {16'h0, s_lup_tdata[71:0]}; din[1] = {16'h0, s_lup_tdata[143:72]};
                        crdy = cam_lup_req_tready; rspv = cam_lup_rsp_tvalid; rspd = cam_lup_rsp_tdata;
                        a_srdy = s_lup_tready; a_mv = cam_lup_req_tvalid; a_md = {16'h0, cam_lup_req_tdata};
                        a_rspv = m_lup_rsp_tvalid; a_crdy = cam_lup_rsp_tready; a_out = lup_outstanding;
                        a_rd0 = m_lup_rsp_tdata[87:0]; a_rd1 = m_lup_rsp_tdata[175:88];
                    end else begin
                        cn = "upd"; vld = s_upd_tvalid; rsprdy = m_upd_rsp_tready;
                        din[0] = s_upd_tdata[87:0]; din[1] = s_upd_tdata[175:88];
                        crdy = cam_upd_req_tready; rspv = cam_upd_rsp_tvalid; rspd = cam_upd_rsp_tdata;
                        a_srdy = s_upd_tready; a_mv = cam_upd_req_tvalid; a_md = cam_upd_req_tdata;
                        a_rspv = m_upd_rsp_tvalid; a_crdy = cam_upd_rsp_tready; a_out = upd_outstanding;
                        a_rd0 = m_upd_rsp_tdata[87:0]; a_rd1 = m_upd_rsp_tdata[175:88];
                    end
                    // Grant: first valid channel from rr when the slot is free and fewer than 16 are outstanding.
                    gnt = -1;
                    if ((!m_rv[c] || crdy) && m_cnt[c] < 16) begin
                        for (int k = 0; k < 2; k++) begin
                            if (gnt < 0 && vld[(m_rr[c] + k) % 2]) gnt = (m_rr[c] + k) % 2;
                        end
                    end
                    e_srdy = '0;
                    if (gnt >= 0) e_srdy[gnt] = 1'b1;
                    e_rspv = '0;
                    e_crdy = 1'b0;
                    if (m_cnt[c] > 0) begin
                        ch = m_ord[c][m_hd[c]];
                        e_crdy = rsprdy[ch];
                        if (rspv) e_rspv[ch] = 1'b1;
                    end else if (rspv) begin
                        perr_set = 1;
                    end
                    chk({cn, ".s_tready"}, 256'(a_srdy), 256'(e_srdy));
                    chk({cn, ".cam_tvalid"}, 256'(a_mv), 256'(m_rv[c]));
                    if (m_rv[c]) chk({cn, ".cam_tdata"}, 256'(a_md), 256'(m_rd[c]));
                    chk({cn, ".rsp_tvalid"}, 256'(a_rspv), 256'(e_rspv));
                    chk({cn, ".cam_rsp_tready"}, 256'(a_crdy), 256'(e_crdy));
                    chk({cn, ".outstanding"}, 256'(a_out), 256'(m_cnt[c]));
                    chk({cn, ".rsp_tdata0"}, 256'(a_rd0), 256'(rspd));
                    chk({cn, ".rsp_tdata1"}, 256'(a_rd1), 256'(rspd));
                    tail = (m_hd[c] + m_cnt[c]) % 16;
                    if (gnt >= 0) begin
                        m_rv[c] = 1; m_rd[c] = din[gnt];
                        m_ord[c][tail] = gnt; m_cnt[c]++;
                        m_rr[c] = (gnt + 1) % 2;
                    end else if (crdy) begin
                        m_rv[c] = 0;
                    end
                    if (rspv && e_crdy) begin
                        m_hd[c] = (m_hd[c] + 1) % 16;
                        m_cnt[c]--;
                    end
                end
                if (perr_set) m_perr = 1;
            end
        end
    end

    task automatic adv();
        @(posedge ap_clk);
        #1;
    endtask

    // n cycles of streaming; a source advances its data only once accepted.
    task automatic run(input int n);
        logic [1:0] la, ua;
        repeat (n) begin
            @(negedge ap_clk);
            la = s_lup_tready;
            ua = s_upd_tready;
            adv();
            for (int i = 0; i < 2; i++) begin
                if (la[i]) lup_d[i] = lup_d[i] + 88'd1;
                if (ua[i]) upd_d[i] = upd_d[i] + 88'd1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        ap_rst_n = 1'b0;
        s_lup_tvalid = '0; s_upd_tvalid = '0;
        lup_d[0] = '0; lup_d[1] = '0; upd_d[0] = '0; upd_d[1] = '0;
        cam_lup_req_tready = 1'b0; cam_upd_req_tready = 1'b0;
        cam_lup_rsp_tdata = '0; cam_lup_rsp_tvalid = 1'b0;
        cam_upd_rsp_tdata = '0; cam_upd_rsp_tvalid = 1'b0;
        m_lup_rsp_tready = '0; m_upd_rsp_tready = '0;
        repeat (3) adv();
        ap_rst_n = 1'b1;
        adv();

        // Simultaneous lookups from both channels, then in-order replies.
        lup_d[0] = 88'hA0; lup_d[1] = 88'hA1;
        s_lup_tvalid = 2'b11; cam_lup_req_tready = 1'b1; m_lup_rsp_tready = 2'b11;
        @(negedge ap_clk); chk("t1.grant_ch0", 256'(s_lup_tready), 256'(2'b01));
        adv(); s_lup_tvalid = 2'b10;
        @(negedge ap_clk);
        chk("t1.cam_ch0_data", 256'(cam_lup_req_tdata), 256'(72'hA0));
        chk("t1.grant_ch1", 256'(s_lup_tready), 256'(2'b10));
        adv(); s_lup_tvalid = 2'b00;
        @(negedge ap_clk);
        chk("t1.cam_ch1_data", 256'(cam_lup_req_tdata), 256'(72'hA1));
        chk("t1.outstanding2", 256'(lup_outstanding), 256'(5'd2));
        adv(); cam_lup_rsp_tvalid = 1'b1; cam_lup_rsp_tdata = 88'hA;
        @(negedge ap_clk);
        chk("t1.rsp_to_ch0", 256'(m_lup_rsp_tvalid), 256'(2'b01));
        chk("t1.rsp_data_A", 256'(m_lup_rsp_tdata[87:0]), 256'(88'hA));
        adv(); cam_lup_rsp_tdata = 88'hB;
        @(negedge ap_clk); chk("t1.rsp_to_ch1", 256'(m_lup_rsp_tvalid), 256'(2'b10));
        adv(); cam_lup_rsp_tvalid = 1'b0;
        @(negedge ap_clk); chk("t1.outstanding0", 256'(lup_outstanding), 256'(5'd0));
        adv();

        // Both update channels always valid: strict alternation, one per cycle.
        upd_d[0] = 88'h1000; upd_d[1] = 88'h2000;
        s_upd_tvalid = 2'b11; cam_upd_req_tready = 1'b1; m_upd_rsp_tready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            chk($sformatf("t2.rr_grant%0d", k), 256'(s_upd_tready), 256'((k % 2 == 1) ? 2'b10 : 2'b01));
            acc = s_upd_tready[k % 2];
            adv();
            if (acc) upd_d[k % 2] = upd_d[k % 2] + 88'd1;
        end
        s_upd_tvalid = 2'b00;
        @(negedge ap_clk); chk("t2.outstanding8", 256'(upd_outstanding), 256'(5'd8));
        adv();
        cam_upd_rsp_tvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cam_upd_rsp_tdata = 88'hC0 + 88'(k);
            @(negedge ap_clk);
            chk($sformatf("t2.rsp_route%0d", k), 256'(m_upd_rsp_tvalid), 256'((k % 2 == 1) ? 2'b10 : 2'b01));
            adv();
        end
        cam_upd_rsp_tvalid = 1'b0;

        // CAM stalled: request held stable; then fill the order FIFO to 16.
        lup_d[0] = 88'h300; s_lup_tvalid = 2'b01; cam_lup_req_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (i > 0) chk($sformatf("t3.hold%0d", i), 256'(cam_lup_req_tdata), 256'(72'h300));
            acc = s_lup_tready[0];
            adv();
            if (acc) lup_d[0] = lup_d[0] + 88'd1;
        end
        cam_lup_req_tready = 1'b1;
        run(20);
        @(negedge ap_clk);
        chk("t3.saturated16", 256'(lup_outstanding), 256'(5'd16));
        chk("t3.full_no_grant", 256'(s_lup_tready), 256'(2'b00));
        adv(); cam_lup_rsp_tvalid = 1'b1; cam_lup_rsp_tdata = 88'h77;
        @(negedge ap_clk);
        chk("t3.pop_no_bypass", 256'(s_lup_tready), 256'(2'b00));
        chk("t3.rsp_ch0", 256'(m_lup_rsp_tvalid), 256'(2'b01));
        adv(); cam_lup_rsp_tvalid = 1'b0;
        @(negedge ap_clk); chk("t3.grant_after_pop", 256'(s_lup_tready), 256'(2'b01));
        adv(); s_lup_tvalid = 2'b00;
        cam_lup_rsp_tvalid = 1'b1;
        repeat (16) adv();
        cam_lup_rsp_tvalid = 1'b0;
        @(negedge ap_clk); chk("t3.drained", 256'(lup_outstanding), 256'(5'd0));
        adv();

        // Reply for ch1 backpressured by the channel for 5 cycles.
        lup_d[1] = 88'h400; s_lup_tvalid = 2'b10;
        @(negedge ap_clk); chk("t4.grant_ch1", 256'(s_lup_tready), 256'(2'b10));
        adv(); s_lup_tvalid = 2'b00;
        cam_lup_rsp_tvalid = 1'b1; cam_lup_rsp_tdata = 88'h55; m_lup_rsp_tready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk($sformatf("t4.stall_rdy%0d", i), 256'(cam_lup_rsp_tready), 256'(0));
            chk($sformatf("t4.stall_vld%0d", i), 256'(m_lup_rsp_tvalid), 256'(2'b10));
            adv();
        end
        m_lup_rsp_tready = 2'b11;
        @(negedge ap_clk);
        chk("t4.deliver_rdy", 256'(cam_lup_rsp_tready), 256'(1));
        chk("t4.deliver_data", 256'(m_lup_rsp_tdata[175:88]), 256'(88'h55));
        adv(); cam_lup_rsp_tvalid = 1'b0;

        // Reply with nothing outstanding raises the sticky error.
        cam_lup_rsp_tvalid = 1'b1; cam_lup_rsp_tdata = 88'h99;
        @(negedge ap_clk);
        chk("t5.no_route", 256'(m_lup_rsp_tvalid), 256'(2'b00));
        chk("t5.no_ready", 256'(cam_lup_rsp_tready), 256'(0));
        chk("t5.err_not_yet", 256'(proto_err), 256'(0));
        adv(); cam_lup_rsp_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk); chk($sformatf("t5.sticky%0d", i), 256'(proto_err), 256'(1));
            adv();
        end

        // Interleaved traffic on both classes with reset asserted mid-burst.
        lup_d[0] = 88'h600; lup_d[1] = 88'h610; upd_d[0] = 88'h700; upd_d[1] = 88'h710;
        s_lup_tvalid = 2'b11; s_upd_tvalid = 2'b11;
        run(6);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("t6.rst_err", 256'(proto_err), 256'(0));
        chk("t6.rst_lup_out", 256'(lup_outstanding), 256'(0));
        chk("t6.rst_upd_tready", 256'(s_upd_tready), 256'(0));
        repeat (3) adv();
        ap_rst_n = 1'b1;
        @(negedge ap_clk); chk("t6.rr_restart", 256'(s_lup_tready), 256'(2'b01));
        adv(); lup_d[0] = lup_d[0] + 88'd1; upd_d[0] = upd_d[0] + 88'd1;
        run(5);
        s_lup_tvalid = 2'b00; s_upd_tvalid = 2'b00;
        @(negedge ap_clk);
        chk("t6.lup_out6", 256'(lup_outstanding), 256'(5'd6));
        chk("t6.upd_out6", 256'(upd_outstanding), 256'(5'd6));
        adv();
        cam_lup_rsp_tvalid = 1'b1; cam_upd_rsp_tvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cam_lup_rsp_tdata = 88'hE00 + 88'(k);
            cam_upd_rsp_tdata = 88'hF00 + 88'(k);
            adv();
        end
        cam_lup_rsp_tvalid = 1'b0; cam_upd_rsp_tvalid = 1'b0;
        @(negedge ap_clk);
        chk("t6.end_lup_out", 256'(lup_outstanding), 256'(0));
        chk("t6.end_upd_out", 256'(upd_outstanding), 256'(0));
        chk("t6.end_err", 256'(proto_err), 256'(0));
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
